// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SLL/SRL/SRA, ROR when SHIFTER_ROTATE_EN is defined), one
// register per shift level and valid/ready flow control on both sides.
module shifter_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);
    logic [SHW-1:0]   v_q, v_d, adv, iv, ld;
    logic [WIDTH-1:0] d_q [SHW];
    logic [WIDTH-1:0] d_d [SHW];
    logic [WIDTH-1:0] ix [SHW];
    logic [1:0]       op_q [SHW];
    logic [1:0]       op_d [SHW];
    logic [1:0]       iop [SHW];
    logic [SHW-1:0]   sh_q [SHW];
    logic [SHW-1:0]   sh_d [SHW];
    logic [SHW-1:0]   ish [SHW];
    logic             s_q [SHW];
    logic             s_d [SHW];
    logic             isg [SHW];

    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x, input logic [1:0] op,
                                             input logic sg, input logic en, input int k);
        logic [WIDTH-1:0] f;
        int s;
        s = 1 << k;
        f = sg ? ~({WIDTH{1'b1}} >> s) : '0;
        if (!en) return x;
        case (op)
            2'b00: return x << s;
            2'b10: return (x >> s) | f;
`ifdef SHIFTER_ROTATE_EN
            2'b11: return (x >> s) | (x << (WIDTH - s));
`endif
            default: return x >> s;
        endcase
    endfunction

    assign in_ready  = adv[0];
    assign out_valid = v_q[SHW-1];
    assign out_data  = d_q[SHW-1];
    assign out_zero  = out_data == '0;
    assign ld        = adv & iv;

    // Advance chain from the output back to the input, and what feeds each stage.
    always_comb begin
        adv[SHW-1] = out_ready || !v_q[SHW-1];
        for (int k = SHW - 2; k >= 0; k--) adv[k] = !v_q[k] || adv[k+1];
        iv[0]  = in_valid;
        ix[0]  = in_data;
        iop[0] = in_op;
        ish[0] = in_shamt;
        isg[0] = in_data[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            iv[k]  = v_q[k-1];
            ix[k]  = d_q[k-1];
            iop[k] = op_q[k-1];
            ish[k] = sh_q[k-1];
            isg[k] = s_q[k-1];
        end
    end

    // Next stage state: load the shifted value on advance, keep data still across bubbles.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            v_d[k]  = adv[k] ? iv[k] : v_q[k];
            d_d[k]  = ld[k] ? lvl(ix[k], iop[k], isg[k], ish[k][0], k) : d_q[k];
            op_d[k] = ld[k] ? iop[k] : op_q[k];
            sh_d[k] = ld[k] ? ish[k] >> 1 : sh_q[k];
            s_d[k]  = ld[k] ? isg[k] : s_q[k];
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                d_q[k]  <= '0;
                op_q[k] <= '0;
                sh_q[k] <= '0;
                s_q[k]  <= 1'b0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < SHW; k++) begin
                d_q[k]  <= d_d[k];
                op_q[k] <= op_d[k];
                sh_q[k] <= sh_d[k];
                s_q[k]  <= s_d[k];
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed checks of shifter_pipe at WIDTH=32.
module tb_shifter_pipe;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_zero;
    logic [31:0] in_data = '0, out_data;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] got[$];
    int          got_cyc[$];

    shifter_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [31:0] d, input logic [1:0] op, input logic [4:0] sh,
                       output logic [31:0] r, output logic z, output int lat);
        in_data = d; in_op = op; in_shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick; lat++; end
        r = out_data;
        z = out_zero;
        if (!out_valid) lat = -1;
        tick;
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h want 0", out_data); end
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL rst_zero got %b want 1", out_zero); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h11 * (i + 1); in_op = 2'b00; in_shamt = 5'd0; in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        tick; tick;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_valid got %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL async_data got %h want 0", out_data); end
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL async_zero got %b want 1", out_zero); end
        tick;
        rst = 1'b0;
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got %b want 1", in_ready); end
        repeat (10) tick;
        total++; if (got.size() != 0) begin bad++; $display("FAIL discarded got %0d outputs want 0", got.size()); end
    endtask

    task automatic test_modes;
        logic [31:0] d[3] = '{32'h0000_00F0, 32'h8000_0000, 32'h8000_0000};
        logic [1:0]  op[3] = '{2'b00, 2'b01, 2'b10};
        logic [4:0]  sh[3] = '{5'd4, 5'd31, 5'd31};
        logic [31:0] e[3] = '{32'h0000_0F00, 32'h0000_0001, 32'hFFFF_FFFF};
        logic [31:0] r;
        logic        z;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            one(d[i], op[i], sh[i], r, z, lat);
            total++; if (r !== e[i]) begin bad++; $display("FAIL mode%0d_data got %h want %h", i, r, e[i]); end
            total++; if (lat != 5) begin bad++; $display("FAIL mode%0d_latency got %0d want 5", i, lat); end
            total++; if (z !== 1'b0) begin bad++; $display("FAIL mode%0d_zero got %b want 0", i, z); end
        end
    endtask

    task automatic test_back_to_back;
        int nr = 0;
        logic [31:0] e;
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = i; in_op = 2'b00; in_shamt = i[4:0]; in_valid = 1'b1;
            #1;
            if (!in_ready) nr++;
            tick;
        end
        in_valid = 1'b0;
        repeat (10) tick;
        total++; if (nr != 0) begin bad++; $display("FAIL b2b_ready got %0d stalls want 0", nr); end
        total++; if (got.size() != 32) begin bad++; $display("FAIL b2b_count got %0d want 32", got.size()); end
        for (int j = 0; j < 32 && j < got.size(); j++) begin
            e = 32'(j) << j;
            total++; if (got[j] !== e) begin bad++; $display("FAIL b2b_data%0d got %h want %h", j, got[j], e); end
        end
        if (got.size() == 32) begin
            total++;
            if (got_cyc[31] - got_cyc[0] != 31) begin
                bad++; $display("FAIL b2b_consecutive got span %0d want 31", got_cyc[31] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure;
        int acc = 0;
        logic have = 1'b0, stable = 1'b1;
        logic [31:0] held = '0, e;
        got.delete(); got_cyc.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c == 10) begin
                total++; if (acc != 5) begin bad++; $display("FAIL bp_accepted got %0d want 5", acc); end
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got %b want 0", in_ready); end
                total++; if (!have || !stable) begin bad++; $display("FAIL bp_stable got have=%b stable=%b want 1 1", have, stable); end
                total++; if (held !== 32'd200) begin bad++; $display("FAIL bp_head got %h want %h", held, 32'd200); end
                out_ready = 1'b1;
            end
            in_data = 100 + acc; in_op = 2'b00; in_shamt = 5'd1; in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            if (c < 10 && out_valid) begin
                if (!have) begin held = out_data; have = 1'b1; end
                else if (out_data !== held) stable = 1'b0;
            end
            tick;
        end
        in_valid = 1'b0;
        repeat (12) tick;
        total++; if (acc <= 5) begin bad++; $display("FAIL bp_resume got %0d accepted want >5", acc); end
        total++; if (got.size() != acc) begin bad++; $display("FAIL bp_count got %0d want %0d", got.size(), acc); end
        for (int j = 0; j < got.size(); j++) begin
            e = 32'(100 + j) << 1;
            total++; if (got[j] !== e) begin bad++; $display("FAIL bp_data%0d got %h want %h", j, got[j], e); end
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] r;
        logic        z;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            one(32'hDEAD_BEEF, 2'(i), 5'd0, r, z, lat);
            total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL shamt0_op%0d got %h want deadbeef", i, r); end
        end
        one(32'h0000_0001, 2'b01, 5'd1, r, z, lat);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL srl_out_data got %h want 0", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL srl_out_zero got %b want 1", z); end
        one(32'hF000_0000, 2'b10, 5'd4, r, z, lat);
        total++; if (r !== 32'hFF00_0000) begin bad++; $display("FAIL sra4 got %h want ff000000", r); end
        one(32'h7000_0000, 2'b10, 5'd4, r, z, lat);
        total++; if (r !== 32'h0700_0000) begin bad++; $display("FAIL sra_pos got %h want 07000000", r); end
    endtask

    task automatic test_op3;
        logic [31:0] r, e;
        logic        z;
        int          lat;
`ifdef SHIFTER_ROTATE_EN
        e = 32'h8000_0000;
`else
        e = 32'h0000_0000;
`endif
        one(32'h0000_0001, 2'b11, 5'd1, r, z, lat);
        total++; if (r !== e) begin bad++; $display("FAIL op3 got %h want %h", r, e); end
`ifdef SHIFTER_ROTATE_EN
        e = 32'h3400_0012;
`else
        e = 32'h0000_0012;
`endif
        one(32'h0000_1234, 2'b11, 5'd8, r, z, lat);
        total++; if (r !== e) begin bad++; $display("FAIL op3_by8 got %h want %h", r, e); end
    endtask

    initial begin
        test_reset;
        test_modes;
        test_back_to_back;
        test_backpressure;
        test_boundaries;
        test_op3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
